// File: rtl/ym_timer_pkg.sv
// Shared constants for the YM2610 timer register front-end: register map,
// CONFIG bit positions and the Z80 port-select encoding.
package ym_timer_pkg;

    localparam logic [7:0] REG_TA_HI = 8'h24;
    localparam logic [7:0] REG_TA_LO = 8'h25;
    localparam logic [7:0] REG_TB    = 8'h26;
    localparam logic [7:0] REG_CTRL  = 8'h27;

    localparam int CFG_LOAD_A = 0;
    localparam int CFG_LOAD_B = 1;
    localparam int CFG_IRQ_A  = 2;
    localparam int CFG_IRQ_B  = 3;
    localparam int CFG_CLR_A  = 4;
    localparam int CFG_CLR_B  = 5;

    typedef enum logic [1:0] {
        PORT_ADDR_A = 2'd0,
        PORT_DATA_A = 2'd1,
        PORT_ADDR_B = 2'd2,
        PORT_DATA_B = 2'd3
    } port_sel_e;

endpackage

// File: rtl/ym_bus_sync.sv
// Two-flop synchroniser for an asynchronous Z80 strobe, with a registered
// rising-edge detector on the synchronised level.
module ym_bus_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/ym_timer_regs.sv
// YM2610 timer register front-end: Z80 bus sync, 0x24-0x27 decode, run
// pulses, TICK_144 prescaler and status reads. Option: YM_TIMER_READBACK_EN.
import ym_timer_pkg::*;

module ym_timer_regs #(
    parameter int PRESCALE    = 144,
    parameter int BUSY_CYCLES = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       nCS,
    input  logic       nWR,
    input  logic       nRD,
    input  logic [1:0] ADDR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    input  logic       FLAG_A,
    input  logic       FLAG_B,
    output logic [9:0] YMTIMER_TA_LOAD,
    output logic [7:0] YMTIMER_TB_LOAD,
    output logic [5:0] YMTIMER_CONFIG,
    output logic       set_run_A,
    output logic       clr_run_A,
    output logic       set_run_B,
    output logic       clr_run_B,
    output logic       TICK_144,
    output logic       BUSY
);

    localparam int PW = $clog2(PRESCALE);
    localparam int BW = $clog2(BUSY_CYCLES + 1);

    logic      w_wr_level;
    logic      w_wr_rise;
    logic      w_rd_level;
    logic      w_rd_rise;

    ym_bus_sync u_wr_sync (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (~nCS & ~nWR),
        .o_level (w_wr_level),
        .o_rise  (w_wr_rise)
    );

    ym_bus_sync u_rd_sync (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_async (~nCS & ~nRD),
        .o_level (w_rd_level),
        .o_rise  (w_rd_rise)
    );

    // ADDR/DIN ride a matching two-stage pipe so they line up with the strobe.
    logic [1:0] r_addr_m;
    logic [7:0] r_din_m;
    port_sel_e  r_port_s;
    logic [7:0] r_din_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr_m <= 2'd0;
            r_din_m  <= 8'h00;
            r_port_s <= PORT_ADDR_A;
            r_din_s  <= 8'h00;
        end else begin
            r_addr_m <= ADDR;
            r_din_m  <= DIN;
            r_port_s <= port_sel_e'(r_addr_m);
            r_din_s  <= r_din_m;
        end
    end

    logic w_addr_wr;
    logic w_data_wr;
    logic w_reg_wr;

    assign w_addr_wr = w_wr_rise & ((r_port_s == PORT_ADDR_A) | (r_port_s == PORT_ADDR_B));
    assign w_data_wr = w_wr_rise & ((r_port_s == PORT_DATA_A) | (r_port_s == PORT_DATA_B));

    logic       r_bank_b;
    logic [7:0] r_reg_addr;
    logic [9:0] r_ta_load;
    logic [7:0] r_tb_load;
    logic [3:0] r_cfg_lo;
    logic [1:0] r_cfg_clr;
    logic       r_set_run_a;
    logic       r_clr_run_a;
    logic       r_set_run_b;
    logic       r_clr_run_b;

    assign w_reg_wr = w_data_wr & ~r_bank_b & (r_port_s == PORT_DATA_A);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bank_b    <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_ta_load   <= 10'd0;
            r_tb_load   <= 8'h00;
            r_cfg_lo    <= 4'd0;
            r_cfg_clr   <= 2'd0;
            r_set_run_a <= 1'b0;
            r_clr_run_a <= 1'b0;
            r_set_run_b <= 1'b0;
            r_clr_run_b <= 1'b0;
        end else begin
            // Flag-clear strobes and run pulses live for a single CLK.
            r_cfg_clr   <= 2'd0;
            r_set_run_a <= 1'b0;
            r_clr_run_a <= 1'b0;
            r_set_run_b <= 1'b0;
            r_clr_run_b <= 1'b0;
            if (w_addr_wr) begin
                r_reg_addr <= r_din_s;
                r_bank_b   <= (r_port_s == PORT_ADDR_B);
            end
            if (w_reg_wr) begin
                case (r_reg_addr)
                    REG_TA_HI: r_ta_load[9:2] <= r_din_s;
                    REG_TA_LO: r_ta_load[1:0] <= r_din_s[1:0];
                    REG_TB:    r_tb_load      <= r_din_s;
                    REG_CTRL: begin
                        r_cfg_lo    <= r_din_s[3:0];
                        r_cfg_clr   <= r_din_s[CFG_CLR_B:CFG_CLR_A];
                        r_set_run_a <=  r_din_s[CFG_LOAD_A] & ~r_cfg_lo[CFG_LOAD_A];
                        r_clr_run_a <= ~r_din_s[CFG_LOAD_A] &  r_cfg_lo[CFG_LOAD_A];
                        r_set_run_b <=  r_din_s[CFG_LOAD_B] & ~r_cfg_lo[CFG_LOAD_B];
                        r_clr_run_b <= ~r_din_s[CFG_LOAD_B] &  r_cfg_lo[CFG_LOAD_B];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Any data-port write, decoded or not, (re)starts the busy window.
    logic [BW-1:0] r_busy_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_busy_cnt <= '0;
        end else if (w_data_wr) begin
            r_busy_cnt <= BW'(BUSY_CYCLES);
        end else if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
        end
    end

    logic [PW-1:0] r_presc;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc <= '0;
        end else if (r_presc == PW'(PRESCALE - 1)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    logic [7:0] w_dout;
    logic [7:0] w_data_rd;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case statements can infer a latch.
        w_data_rd = 8'hFF;
`ifdef YM_TIMER_READBACK_EN
        case (r_reg_addr)
            REG_TA_HI: w_data_rd = r_ta_load[9:2];
            REG_TA_LO: w_data_rd = {6'b0, r_ta_load[1:0]};
            REG_TB:    w_data_rd = r_tb_load;
            REG_CTRL:  w_data_rd = {4'b0, r_cfg_lo};
            default:   w_data_rd = 8'hFF;
        endcase
`endif
        w_dout = 8'h00;
        if (w_rd_level) begin
            case (r_port_s)
                PORT_ADDR_A, PORT_ADDR_B: w_dout = {BUSY, 5'b0, FLAG_B, FLAG_A};
                PORT_DATA_A:              w_dout = w_data_rd;
                default:                  w_dout = 8'hFF;
            endcase
        end
    end

    assign DOUT            = w_dout;
    assign YMTIMER_TA_LOAD = r_ta_load;
    assign YMTIMER_TB_LOAD = r_tb_load;
    assign YMTIMER_CONFIG  = {r_cfg_clr, r_cfg_lo};
    assign set_run_A       = r_set_run_a;
    assign clr_run_A       = r_clr_run_a;
    assign set_run_B       = r_set_run_b;
    assign clr_run_B       = r_clr_run_b;
    assign TICK_144        = (r_presc == PW'(PRESCALE - 1));
    assign BUSY            = (r_busy_cnt != '0);

endmodule
